serial_to_parallel: RTL and testbench
=====================================

Name: serial_to_parallel

Overview:
Deserializer that collects a stream of N-bit words, one per enabled cycle, into a Length-entry register array. It presents the array in parallel once the requested number of words has been captured. It is the receive-side counterpart of the parallel-to-serial shifter and sits between a serial word source (e.g. a layer output stream) and logic that consumes a whole vector at once.

Parameters:
N, 8, width of each data word
Length, 3, number of word registers (maximum words per frame)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
srst_i  input  1  synchronous reset, active high; same effect as rst_ni but on clk_i edge
start_i  input  1  begin a frame; sampled only in IDLE
word_count_i  input  $clog2(Length+1)  words to capture this frame; sampled with start_i
en_i  input  1  data_i valid this cycle
data_i  input  N  serial word in
ready_o  output  1  high in COLLECT; a word is accepted when en_i && ready_o
data_o  output  N x Length (unpacked array [Length-1:0])  captured words, data_o[0] = first word
count_o  output  $clog2(Length+1)  words captured so far in current/last frame
running_o  output  1  high while in COLLECT
done_o  output  1  single-cycle pulse, frame complete
assert_on_i  input  1  enables simulation assertions; no functional effect

Behaviour:
- Reset (rst_ni low, async; or srst_i high, sync): state=IDLE, all data_o entries=0, count_o=0, ready_o=0, running_o=0, done_o=0. Internal target count=0. srst_i has priority over every other input.
- States: IDLE, COLLECT, DONE.
- IDLE, start_i=1:
  - latch target = min(word_count_i, Length); clear count_o to 0; clear all data_o entries to 0.
  - if target==0, go to DONE; otherwise go to COLLECT.
  - en_i in the same cycle as start_i is ignored (no word accepted).
- IDLE, start_i=0: hold. data_o and count_o keep the last frame's values.
- COLLECT:
  - ready_o=running_o=1.
  - On en_i=1: data_o[count_o] <= data_i and count_o <= count_o+1, both at the clock edge.
  - If the accepted word makes count_o == target, go to DONE on that edge.
  - start_i is ignored while in COLLECT. en_i=0 holds all state, with no timeout.
- DONE: lasts exactly one cycle. done_o=1, ready_o=0, en_i ignored. Next state is IDLE.
  - Latency: done_o is high in the cycle after the edge that captured the last word.
  - For target==0: done_o is high in the cycle after the start_i edge.
- start_i asserted in DONE is ignored; it must be reasserted in IDLE.
- data_o entries at index >= target remain 0 for that frame.
- count_o never exceeds target; no writes occur beyond index target-1.
- word_count_i > Length is clamped to Length. The clamp is flagged by an assertion when assert_on_i=1 (warning only).
- Reset mid-frame (async or sync): immediate return to IDLE with cleared outputs; no done_o pulse.
- Assertions (when assert_on_i=1):
  - count_o <= target;
  - done_o never high for two consecutive cycles;
  - ready_o and done_o never both high.

Test Plan:
- Reset then idle: rst_ni=0 for 2 cycles, release -> data_o all 0, count_o=0, ready_o=0, done_o=0.
- Full frame, Length=3, N=8: start_i with word_count_i=3; then en_i for 3 consecutive cycles with data 0xA1,0xB2,0xC3 -> data_o={0xA1,0xB2,0xC3} (index 0..2), count_o=3, done_o high exactly one cycle after the 3rd edge, ready_o low from DONE onward.
- Gapped/partial frame: word_count_i=2; en_i pattern 1,0,0,1 with data 0x11, x, x, 0x22 -> data_o[0]=0x11, data_o[1]=0x22, data_o[2]=0, count_o=2, single done_o pulse.
- Boundaries:
  - word_count_i=0 -> done_o pulses one cycle after start, data_o all 0, no word accepted.
  - word_count_i=3 with Length=3 plus a 4th en_i beat after DONE -> 4th beat ignored, count_o stays 3.
  - Clamp case: Length=2 instance with word_count_i=3 -> clamped to 2 words, assertion warning fires.
- Reset mid-operation: after 1 of 3 words captured, pulse srst_i -> next cycle IDLE, data_o all 0, count_o=0, no done_o. Repeat with async rst_ni asserted mid-cycle -> outputs clear without waiting for a clock edge.
- Back-to-back frames: a second start_i in the cycle after DONE (state IDLE) with new data 0x01,0x02,0x03 -> previous contents cleared at start, new values captured. A start_i asserted during COLLECT has no effect.

Source files
------------

// File: rtl/serial_to_parallel_if.sv
// Word-stream handshake and parallel result bundle for serial_to_parallel.
// The master is the word source and vector consumer; the slave is the deserializer.
interface serial_to_parallel_if #(
  parameter int N      = 8,
  parameter int Length = 3
);
  localparam int CW = $clog2(Length + 1);

  logic          start_i;
  logic [CW-1:0] word_count_i;
  logic          en_i;
  logic [N-1:0]  data_i;
  logic          ready_o;
  logic [N-1:0]  data_o [Length-1:0];
  logic [CW-1:0] count_o;
  logic          running_o;
  logic          done_o;

  modport master (
    output start_i, word_count_i, en_i, data_i,
    input  ready_o, data_o, count_o, running_o, done_o
  );

  modport slave (
    input  start_i, word_count_i, en_i, data_i,
    output ready_o, data_o, count_o, running_o, done_o
  );
endinterface

// File: rtl/serial_to_parallel.sv
// Deserializer: gathers up to Length N-bit words, one per accepted beat, into a
// parallel register array and pulses done_o once the requested count is captured.
module serial_to_parallel #(
  parameter int N      = 8,
  parameter int Length = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                srst_i,
  input  logic                assert_on_i,
  serial_to_parallel_if.slave bus
);
  localparam int CW = $clog2(Length + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] target_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] target_new;
  logic [N-1:0]  data_q [Length-1:0];
  logic          ready_q;
  logic          running_q;
  logic          done_q;
  logic          clamp;
  logic          done_d1;

  assign clamp      = bus.word_count_i > CW'(Length);
  assign target_new = clamp ? CW'(Length) : bus.word_count_i;
  assign count_nxt  = count_q + CW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      target_q  <= '0;
      count_q   <= '0;
      ready_q   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < Length; i++) data_q[i] <= '0;
    end else if (srst_i) begin
      state_q   <= IDLE;
      target_q  <= '0;
      count_q   <= '0;
      ready_q   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < Length; i++) data_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            target_q <= target_new;
            count_q  <= '0;
            for (int i = 0; i < Length; i++) data_q[i] <= '0;
            // A zero-length frame completes without ever opening the port.
            if (target_new == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= COLLECT;
              ready_q   <= 1'b1;
              running_q <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (bus.en_i) begin
            for (int i = 0; i < Length; i++) begin
              if (count_q == CW'(i)) data_q[i] <= bus.data_i;
            end
            count_q <= count_nxt;
            if (count_nxt == target_q) begin
              state_q   <= DONE;
              ready_q   <= 1'b0;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          ready_q   <= 1'b0;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_o    = data_q;
  assign bus.count_o   = count_q;
  assign bus.ready_o   = ready_q;
  assign bus.running_o = running_q;
  assign bus.done_o    = done_q;

  // Previous-cycle done, used only by the protocol checks below.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) done_d1 <= 1'b0;
    else         done_d1 <= done_q;
  end

  always @(posedge clk_i) begin
    if (rst_ni && !srst_i && assert_on_i) begin
      assert (count_q <= target_q)
        else $error("count_o %0d exceeds target %0d", count_q, target_q);
      assert (!(done_q && done_d1))
        else $error("done_o high on two consecutive cycles");
      assert (!(ready_q && done_q))
        else $error("ready_o and done_o both high");
      if (state_q == IDLE && bus.start_i) begin
        assert (!clamp)
          else $warning("word_count_i %0d clamped to %0d", bus.word_count_i, Length);
      end
    end
  end
endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel: a word scoreboard is filled as beats are
// accepted by the bench's frame model and drained when done_o is observed.
module tb_serial_to_parallel;
  localparam int N  = 8;
  localparam int L  = 3;
  localparam int CW = $clog2(L + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic srst  = 1'b0;

  always #5 clk = ~clk;

  serial_to_parallel_if #(.N(N), .Length(L)) bus ();
  serial_to_parallel_if #(.N(N), .Length(2)) bus2 ();

  serial_to_parallel #(.N(N), .Length(L)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .srst_i(srst), .assert_on_i(1'b1), .bus(bus)
  );

  serial_to_parallel #(.N(N), .Length(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .srst_i(srst), .assert_on_i(1'b1), .bus(bus2)
  );

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int done_base;

  logic [N-1:0] exp_q [$];
  int m_target;
  int m_count;
  bit m_collect;

  always @(posedge clk) if (bus.done_o) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic start_frame(input int wc, input logic en_too);
    bus.start_i      = 1'b1;
    bus.word_count_i = CW'(wc);
    bus.en_i         = en_too;
    bus.data_i       = 8'h55;
    tick();
    bus.start_i = 1'b0;
    bus.en_i    = 1'b0;
    m_target  = (wc > L) ? L : wc;
    m_count   = 0;
    m_collect = (m_target != 0);
    exp_q.delete();
  endtask

  task automatic beat(input logic [N-1:0] d);
    bus.en_i   = 1'b1;
    bus.data_i = d;
    if (m_collect) begin
      exp_q.push_back(d);
      m_count++;
      if (m_count == m_target) m_collect = 1'b0;
    end
    tick();
    bus.en_i = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    logic [N-1:0] e;
    int got;
    got = 0;
    for (int i = 0; i < L; i++) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got++;
      end else begin
        e = '0;
      end
      chk($sformatf("%s_data%0d", tag, i), 32'(bus.data_o[i]), 32'(e));
    end
    chk({tag, "_count"}, 32'(bus.count_o), 32'(got));
  endtask

  task automatic check_cleared(input string tag);
    for (int i = 0; i < L; i++)
      chk($sformatf("%s_data%0d", tag, i), 32'(bus.data_o[i]), 32'h0);
    chk({tag, "_count"}, 32'(bus.count_o), 32'h0);
  endtask

  initial begin
    bus.start_i       = 1'b0;
    bus.word_count_i  = '0;
    bus.en_i          = 1'b0;
    bus.data_i        = '0;
    bus2.start_i      = 1'b0;
    bus2.word_count_i = '0;
    bus2.en_i         = 1'b0;
    bus2.data_i       = '0;
    m_target  = 0;
    m_count   = 0;
    m_collect = 1'b0;

    // Reset, then idle
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check_cleared("rst");
    chk("rst_ready", 32'(bus.ready_o), 32'h0);
    chk("rst_running", 32'(bus.running_o), 32'h0);
    chk("rst_done", 32'(bus.done_o), 32'h0);

    // Full frame, then a 4th beat during DONE
    done_base = done_cnt;
    start_frame(3, 1'b0);
    chk("full_ready", 32'(bus.ready_o), 32'h1);
    chk("full_running", 32'(bus.running_o), 32'h1);
    beat(8'hA1);
    chk("full_cnt1", 32'(bus.count_o), 32'h1);
    beat(8'hB2);
    chk("full_done_early", 32'(bus.done_o), 32'h0);
    beat(8'hC3);
    chk("full_done", 32'(bus.done_o), 32'h1);
    chk("full_ready_done", 32'(bus.ready_o), 32'h0);
    check_frame("full");
    beat(8'hD4);
    chk("extra_done", 32'(bus.done_o), 32'h0);
    chk("extra_count", 32'(bus.count_o), 32'h3);
    chk("extra_data2", 32'(bus.data_o[2]), 32'hC3);
    chk("full_pulses", 32'(done_cnt - done_base), 32'h1);

    // Back-to-back: start in the IDLE cycle right after DONE clears old contents
    done_base = done_cnt;
    start_frame(3, 1'b0);
    check_cleared("b2b_clear");
    beat(8'h01);
    beat(8'h02);
    beat(8'h03);
    chk("b2b_done", 32'(bus.done_o), 32'h1);
    check_frame("b2b");
    // start asserted in DONE is ignored
    bus.start_i = 1'b1;
    bus.word_count_i = CW'(2);
    tick();
    bus.start_i = 1'b0;
    chk("done_start_running", 32'(bus.running_o), 32'h0);
    tick();
    chk("done_start_idle", 32'(bus.running_o), 32'h0);
    chk("done_start_keep", 32'(bus.data_o[1]), 32'h02);
    chk("b2b_pulses", 32'(done_cnt - done_base), 32'h1);

    // Gapped partial frame
    done_base = done_cnt;
    start_frame(2, 1'b0);
    beat(8'h11);
    tick();
    tick();
    chk("gap_hold", 32'(bus.count_o), 32'h1);
    beat(8'h22);
    chk("gap_done", 32'(bus.done_o), 32'h1);
    check_frame("gap");
    tick();
    chk("gap_pulses", 32'(done_cnt - done_base), 32'h1);

    // Zero-length frame, en_i driven alongside start
    done_base = done_cnt;
    start_frame(0, 1'b1);
    chk("zero_done", 32'(bus.done_o), 32'h1);
    chk("zero_ready", 32'(bus.ready_o), 32'h0);
    check_cleared("zero");
    beat(8'h66);
    chk("zero_after", 32'(bus.done_o), 32'h0);
    chk("zero_count", 32'(bus.count_o), 32'h0);
    chk("zero_pulses", 32'(done_cnt - done_base), 32'h1);

    // start during COLLECT ignored, then synchronous reset mid-frame
    done_base = done_cnt;
    start_frame(3, 1'b0);
    beat(8'h5A);
    bus.start_i = 1'b1;
    bus.word_count_i = CW'(1);
    tick();
    bus.start_i = 1'b0;
    chk("collect_start_cnt", 32'(bus.count_o), 32'h1);
    chk("collect_start_run", 32'(bus.running_o), 32'h1);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    exp_q.delete();
    m_collect = 1'b0;
    check_cleared("srst");
    chk("srst_running", 32'(bus.running_o), 32'h0);
    tick();
    tick();
    chk("srst_pulses", 32'(done_cnt - done_base), 32'h0);

    // Asynchronous reset mid-frame, checked before any clock edge
    done_base = done_cnt;
    start_frame(3, 1'b0);
    beat(8'h77);
    chk("arst_pre", 32'(bus.data_o[0]), 32'h77);
    #3 rst_n = 1'b0;
    #1;
    check_cleared("arst");
    chk("arst_ready", 32'(bus.ready_o), 32'h0);
    #2 rst_n = 1'b1;
    exp_q.delete();
    m_collect = 1'b0;
    tick();
    tick();
    chk("arst_pulses", 32'(done_cnt - done_base), 32'h0);

    // Clamp on the Length=2 instance: word_count 3 captures only 2 words
    bus2.start_i = 1'b1;
    bus2.word_count_i = 2'd3;
    tick();
    bus2.start_i = 1'b0;
    chk("clamp_ready", 32'(bus2.ready_o), 32'h1);
    bus2.en_i = 1'b1;
    bus2.data_i = 8'hAA;
    tick();
    bus2.data_i = 8'hBB;
    tick();
    chk("clamp_done", 32'(bus2.done_o), 32'h1);
    chk("clamp_count", 32'(bus2.count_o), 32'h2);
    bus2.data_i = 8'hCC;
    tick();
    bus2.en_i = 1'b0;
    chk("clamp_count_after", 32'(bus2.count_o), 32'h2);
    chk("clamp_data0", 32'(bus2.data_o[0]), 32'hAA);
    chk("clamp_data1", 32'(bus2.data_o[1]), 32'hBB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
